// File: rtl/dm_store_align.sv
// Store path to data memory: aligns sw/sh/sb requests into word writes with byte
// enables, buffers one pending store, and flags misaligned stores.
//
// state | meaning
// IDLE  | buffer empty, requests always accepted
// FULL  | buffer holds a store, mem_wr_en asserted until mem_ready
module dm_store_align (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   output logic        req_ready,
   output logic        mem_wr_en,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_byteen,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   output logic        exc_ades,
   output logic [31:0] exc_addr,
   input  logic [31:0] chk_addr,
   output logic        chk_hit
);

   typedef enum logic {IDLE, FULL} state_t;

   state_t      state, state_nxt;
   logic        op_valid;
   logic        aligned;
   logic [3:0]  ld_byteen;
   logic [31:0] ld_wdata;
   logic        accept;
   logic        acc_ok;
   logic        acc_bad;

   always_comb begin
      op_valid  = 1'b0;
      aligned   = 1'b0;
      ld_byteen = 4'b0000;
      ld_wdata  = 32'h0;
      case (req_op)
         3'd1: begin
            op_valid  = 1'b1;
            aligned   = (req_addr[1:0] == 2'b00);
            ld_byteen = 4'b1111;
            ld_wdata  = req_data;
         end
         3'd2: begin
            op_valid  = 1'b1;
            aligned   = ~req_addr[0];
            ld_byteen = req_addr[1] ? 4'b1100 : 4'b0011;
            ld_wdata  = {2{req_data[15:0]}};
         end
         3'd3: begin
            op_valid  = 1'b1;
            aligned   = 1'b1;
            ld_byteen = 4'b0001 << req_addr[1:0];
            ld_wdata  = {4{req_data[7:0]}};
         end
         default: ;
      endcase
   end

   assign req_ready = (state == IDLE) || mem_ready;
   assign accept    = req_valid && req_ready && op_valid;
   assign acc_ok    = accept && aligned;
   assign acc_bad   = accept && !aligned;
   assign mem_wr_en = (state == FULL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (acc_ok) state_nxt = FULL;
         FULL: if (mem_ready) state_nxt = acc_ok ? FULL : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr   <= 32'h0;
         mem_byteen <= 4'b0000;
         mem_wdata  <= 32'h0;
      end else if (acc_ok) begin
         mem_addr   <= {req_addr[31:2], 2'b00};
         mem_byteen <= ld_byteen;
         mem_wdata  <= ld_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exc_ades <= 1'b0;
         exc_addr <= 32'h0;
      end else begin
         exc_ades <= acc_bad;
         if (acc_bad) exc_addr <= req_addr;
      end
   end

   // mem_addr[1:0] is always zero, so masking the low bits gives a word compare
   assign chk_hit = mem_wr_en && (((chk_addr ^ mem_addr) & 32'hFFFF_FFFC) == 32'h0);

endmodule

// File: tb/tb_dm_store_align.sv
// Bench for dm_store_align: directed scenarios with a write scoreboard that is
// filled when stores are offered and drained when memory accepts a write.
module tb_dm_store_align;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic        req_ready;
   logic        mem_wr_en;
   logic [31:0] mem_addr;
   logic [3:0]  mem_byteen;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic        exc_ades;
   logic [31:0] exc_addr;
   logic [31:0] chk_addr;
   logic        chk_hit;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } wr_t;

   wr_t sb_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;

   dm_store_align dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .mem_wr_en  (mem_wr_en),
      .mem_addr   (mem_addr),
      .mem_byteen (mem_byteen),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .exc_ades   (exc_ades),
      .exc_addr   (exc_addr),
      .chk_addr   (chk_addr),
      .chk_hit    (chk_hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A write completes at the next rising edge when mem_wr_en && mem_ready here.
   always @(negedge clk) begin
      if (!reset && mem_wr_en && mem_ready) begin
         wr_t got, exp;
         got = '{addr: mem_addr, be: mem_byteen, data: mem_wdata};
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_write: got addr=%h be=%b data=%h, required no write",
                     mem_addr, mem_byteen, mem_wdata);
         end else begin
            exp = sb_q.pop_front();
            if (got !== exp) begin
               n_fail++;
               $display("FAIL sb_write: got addr=%h be=%b data=%h, required addr=%h be=%b data=%h",
                        got.addr, got.be, got.data, exp.addr, exp.be, exp.data);
            end
         end
      end
   end

   task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_data  = data;
   endtask

   task automatic idle_req();
      req_valid = 1'b0;
      req_op    = 3'd0;
      req_addr  = 32'h0;
      req_data  = 32'h0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      mem_ready = 1'b0;
      chk_addr  = 32'h0;
      idle_req();
      #2;
      n_tests++;
      if ({req_ready, mem_wr_en, exc_ades, chk_hit} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_flags: got rdy/wr/ades/hit=%b, required 1000",
                  {req_ready, mem_wr_en, exc_ades, chk_hit});
      end
      n_tests++;
      if ({mem_addr, mem_byteen, mem_wdata, exc_addr} !== 100'h0) begin
         n_fail++;
         $display("FAIL reset_regs: got addr=%h be=%b data=%h exc_addr=%h, required all zero",
                  mem_addr, mem_byteen, mem_wdata, exc_addr);
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset_mid_store();
      mem_ready = 1'b0;
      drive(3'd1, 32'h0000_1004, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      idle_req();
      @(negedge clk);
      n_tests++;
      if (mem_wr_en !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_full: got mem_wr_en=%b, required 1", mem_wr_en);
      end
      #1 reset = 1'b1;
      #1;
      n_tests++;
      if (mem_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_drop: got mem_wr_en=%b, required 0", mem_wr_en);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      n_tests++;
      if (req_ready !== 1'b1 || mem_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_after: got req_ready=%b mem_wr_en=%b, required 1 0", req_ready, mem_wr_en);
      end
      mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_sw();
      mem_ready = 1'b1;
      drive(3'd1, 32'h0000_1004, 32'h1234_5678);
      sb_q.push_back('{addr: 32'h0000_1004, be: 4'b1111, data: 32'h1234_5678});
      @(posedge clk); #1;
      idle_req();
      @(negedge clk);
      n_tests++;
      if ({mem_wr_en, mem_addr, mem_byteen, mem_wdata} !== {1'b1, 32'h0000_1004, 4'b1111, 32'h1234_5678}) begin
         n_fail++;
         $display("FAIL sw_out: got wr=%b addr=%h be=%b data=%h, required 1 00001004 1111 12345678",
                  mem_wr_en, mem_addr, mem_byteen, mem_wdata);
      end
      @(posedge clk); #1;
      n_tests++;
      if (mem_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL sw_idle: got mem_wr_en=%b, required 0", mem_wr_en);
      end
   endtask

   task automatic test_lanes();
      mem_ready = 1'b1;
      drive(3'd2, 32'h0000_2002, 32'hAAAA_BEEF);
      sb_q.push_back('{addr: 32'h0000_2000, be: 4'b1100, data: 32'hBEEF_BEEF});
      @(posedge clk); #1;
      drive(3'd3, 32'h0000_2003, 32'h0000_00C3);
      sb_q.push_back('{addr: 32'h0000_2000, be: 4'b1000, data: 32'hC3C3_C3C3});
      @(negedge clk);
      n_tests++;
      if ({mem_byteen, mem_wdata} !== {4'b1100, 32'hBEEF_BEEF}) begin
         n_fail++;
         $display("FAIL sh_lanes: got be=%b data=%h, required 1100 beefbeef", mem_byteen, mem_wdata);
      end
      @(posedge clk); #1;
      idle_req();
      @(negedge clk);
      n_tests++;
      if ({mem_wr_en, mem_byteen, mem_wdata} !== {1'b1, 4'b1000, 32'hC3C3_C3C3}) begin
         n_fail++;
         $display("FAIL sb_lanes: got wr=%b be=%b data=%h, required 1 1000 c3c3c3c3",
                  mem_wr_en, mem_byteen, mem_wdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_stall();
      mem_ready = 1'b0;
      drive(3'd3, 32'h0000_0010, 32'h0000_005A);
      sb_q.push_back('{addr: 32'h0000_0010, be: 4'b0001, data: 32'h5A5A_5A5A});
      @(posedge clk); #1;
      drive(3'd3, 32'h0000_0011, 32'h0000_00A5);
      sb_q.push_back('{addr: 32'h0000_0010, be: 4'b0010, data: 32'hA5A5_A5A5});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_tests++;
         if ({req_ready, mem_wr_en, mem_addr, mem_byteen, mem_wdata} !==
             {1'b0, 1'b1, 32'h0000_0010, 4'b0001, 32'h5A5A_5A5A}) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got rdy=%b wr=%b addr=%h be=%b data=%h, required 0 1 00000010 0001 5a5a5a5a",
                     i, req_ready, mem_wr_en, mem_addr, mem_byteen, mem_wdata);
         end
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_release: got req_ready=%b, required 1", req_ready);
      end
      @(posedge clk); #1;
      idle_req();
      @(negedge clk);
      n_tests++;
      if ({mem_wr_en, mem_byteen, mem_wdata} !== {1'b1, 4'b0010, 32'hA5A5_A5A5}) begin
         n_fail++;
         $display("FAIL stall_second: got wr=%b be=%b data=%h, required 1 0010 a5a5a5a5",
                  mem_wr_en, mem_byteen, mem_wdata);
      end
      @(posedge clk); #1;
      n_tests++;
      if (mem_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_drain: got mem_wr_en=%b, required 0", mem_wr_en);
      end
   endtask

   task automatic test_misaligned();
      mem_ready = 1'b1;
      drive(3'd1, 32'h0000_3002, 32'h1111_2222);
      @(posedge clk); #1;
      drive(3'd2, 32'h0000_3001, 32'h3333_4444);
      @(negedge clk);
      n_tests++;
      if ({exc_ades, exc_addr, mem_wr_en} !== {1'b1, 32'h0000_3002, 1'b0}) begin
         n_fail++;
         $display("FAIL mis_sw: got ades=%b exc_addr=%h wr=%b, required 1 00003002 0", exc_ades, exc_addr, mem_wr_en);
      end
      @(posedge clk); #1;
      idle_req();
      @(negedge clk);
      n_tests++;
      if ({exc_ades, exc_addr, mem_wr_en} !== {1'b1, 32'h0000_3001, 1'b0}) begin
         n_fail++;
         $display("FAIL mis_sh: got ades=%b exc_addr=%h wr=%b, required 1 00003001 0", exc_ades, exc_addr, mem_wr_en);
      end
      @(posedge clk); #1;
      n_tests++;
      if ({exc_ades, exc_addr, mem_wr_en} !== {1'b0, 32'h0000_3001, 1'b0}) begin
         n_fail++;
         $display("FAIL mis_end: got ades=%b exc_addr=%h wr=%b, required 0 00003001 0", exc_ades, exc_addr, mem_wr_en);
      end
   endtask

   task automatic test_op_none();
      mem_ready = 1'b1;
      drive(3'd0, 32'h0000_5000, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      drive(3'd5, 32'h0000_5001, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      idle_req();
      n_tests++;
      if ({mem_wr_en, exc_ades} !== 2'b00) begin
         n_fail++;
         $display("FAIL op_none: got wr=%b ades=%b, required 0 0", mem_wr_en, exc_ades);
      end
   endtask

   task automatic test_forward();
      mem_ready = 1'b0;
      drive(3'd1, 32'h0000_4008, 32'hCAFE_F00D);
      sb_q.push_back('{addr: 32'h0000_4008, be: 4'b1111, data: 32'hCAFE_F00D});
      @(posedge clk); #1;
      idle_req();
      chk_addr = 32'h0000_400B;
      #1;
      n_tests++;
      if (chk_hit !== 1'b1) begin
         n_fail++;
         $display("FAIL fwd_hit: got chk_hit=%b, required 1", chk_hit);
      end
      chk_addr = 32'h0000_400C;
      #1;
      n_tests++;
      if (chk_hit !== 1'b0) begin
         n_fail++;
         $display("FAIL fwd_miss: got chk_hit=%b, required 0", chk_hit);
      end
      mem_ready = 1'b1;
      @(posedge clk); #1;
      chk_addr = 32'h0000_4008;
      #1;
      n_tests++;
      if ({chk_hit, mem_wr_en} !== 2'b00) begin
         n_fail++;
         $display("FAIL fwd_idle: got chk_hit=%b wr=%b, required 0 0", chk_hit, mem_wr_en);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_reset_mid_store();
      test_sw();
      test_lanes();
      test_stall();
      test_misaligned();
      test_op_none();
      test_forward();
      repeat (2) @(posedge clk);
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d writes outstanding, required 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion by 100000, required finish earlier");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dm_store_align.md
# dm_store_align

Store-side counterpart of the load extender on the data-memory path. Takes a store request from the MEM stage (sw/sh/sb, byte address, register data), produces word-aligned write data with a 4-bit byte enable, and checks alignment. It holds at most one pending store in a registered buffer and drains it to data memory with a valid/ready handshake, so a stalling memory back-pressures the pipeline. It also raises a one-cycle address-error pulse for misaligned stores and reports word-address hits against the pending store for hazard stalls.

## Interface
- No parameters. Address width is fixed at 32. Data width is fixed at 32.
- `clk` input 1 — single clock, rising edge.
- `reset` input 1 — asynchronous, active-high.
- `req_valid` input 1 — store request present.
- `req_op` input 3 — 0 none, 1 sw, 2 sh, 3 sb; 4–7 are treated as none.
- `req_addr` input 32 — byte address.
- `req_data` input 32 — rt register value; low bits are used for sh and sb.
- `req_ready` output 1 — request accepted this cycle when high together with `req_valid`.
- `mem_wr_en` output 1 — pending write valid.
- `mem_addr` output 32 — word address, `{addr[31:2],2'b00}`.
- `mem_byteen` output 4 — byte enables; bit i covers `wdata[8i+7:8i]`.
- `mem_wdata` output 32 — lane-replicated write data.
- `mem_ready` input 1 — memory accepts the write this cycle.
- `exc_ades` output 1 — one-cycle misaligned-store pulse.
- `exc_addr` output 32 — faulting byte address; holds until the next exception.
- `chk_addr` input 32 — load address to compare.
- `chk_hit` output 1 — combinational: `mem_wr_en && chk_addr[31:2]==mem_addr[31:2]`.

## Operation
- States:
  - IDLE: buffer empty.
  - FULL: buffer holds a store; `mem_wr_en`=1.
- `req_ready` = (state==IDLE) || mem_ready. This allows back-to-back acceptance on the cycle the buffer drains.
- Accept condition: `req_valid && req_ready && op in {1,2,3}`. Requests with op none are consumed and have no effect.
- Alignment rules:
  - sw: `addr[1:0]==0`.
  - sh: `addr[0]==0`.
  - sb: always aligned.
- Misaligned accept:
  - Buffer is not loaded, and no memory write is ever issued for it.
  - `exc_ades`=1 next cycle; `exc_addr`<=req_addr.
  - State still follows the drain rule below.
- Lane generation for an aligned accept:
  - sw: byteen=1111, wdata=req_data.
  - sh: byteen = addr[1] ? 1100 : 0011; wdata={2{req_data[15:0]}}.
  - sb: byteen = 0001<<addr[1:0]; wdata={4{req_data[7:0]}}.
- Transitions:
  - IDLE -> FULL on an aligned accept.
  - FULL -> IDLE on mem_ready with no aligned accept.
  - FULL -> FULL on mem_ready with a simultaneous aligned accept; the buffer is reloaded.
  - FULL with mem_ready=0: hold all mem_* outputs stable. req_ready=0.
- mem_* outputs come directly from the buffer registers and are valid only while `mem_wr_en`=1. Unused lanes in wdata carry the replicated value.

## Timing
- Reset values:
  - state=IDLE.
  - mem_wr_en=0, mem_addr=0, mem_byteen=0, mem_wdata=0.
  - exc_ades=0, exc_addr=0.
  - req_ready=1 (combinational from state).
- Reset mid-operation: a pending store is dropped immediately, asynchronously, and never written.
- Latency:
  - Accept at edge N -> `mem_wr_en`=1 during cycle N+1.
  - The write completes at the first edge where mem_wr_en && mem_ready.
- Throughput: one store per cycle while mem_ready stays high.
- `exc_ades` is high for exactly one cycle per misaligned accept. Two misaligned accepts in consecutive cycles give two consecutive high cycles with exc_addr updated each cycle.
- `chk_hit` is purely combinational. It never asserts in IDLE.

## Test plan
- Reset mid-store:
  - Stimulus: sw 0x0000_1004 data 0xDEAD_BEEF, mem_ready=0, then reset asserted in FULL.
  - Response: mem_wr_en drops immediately. After release, req_ready=1 and no write is ever seen.
- sw, no stall:
  - Stimulus: sw addr 0x0000_1004, data 0x1234_5678, mem_ready=1.
  - Response: next cycle mem_addr=0x0000_1004, byteen=1111, wdata=0x1234_5678; back in IDLE after one cycle.
- sh / sb lanes:
  - Stimulus: sh addr 0x0000_2002 data 0xAAAA_BEEF, followed by sb addr 0x0000_2003 data 0x0000_00C3.
  - Response: sh gives byteen=1100, wdata=0xBEEF_BEEF. sb gives byteen=1000, wdata=0xC3C3_C3C3.
- Stall and back-pressure:
  - Stimulus: sb 0x10, then sb 0x11 offered while mem_ready=0 for 3 cycles, then mem_ready=1.
  - Response: req_ready=0 for 3 cycles with mem_* stable. On release the second store loads on the same edge; two writes are seen in order.
- Misaligned:
  - Stimulus: sw addr 0x0000_3002, then sh addr 0x0000_3001.
  - Response: exc_ades high two consecutive cycles, exc_addr=0x3002 then 0x3001. mem_wr_en never asserts.
- Forward check:
  - Stimulus: pending sw at 0x0000_4008 with mem_ready=0; chk_addr=0x400B, then 0x400C.
  - Response: chk_hit=1 for 0x400B, chk_hit=0 for 0x400C. chk_hit=0 once IDLE.
